fetch_sequencer: RTL

//  Sequences the InstructionFetch memory: owns the program counter (PC), issues fetch addresses and

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_skid_buffer.sv | 92 +++++++++
 rtl/fetch_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    // Fetch control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Width of the opcode field at the top of every instruction word.
    localparam int unsigned OPC_W = 6;

    // Opcode that stops fetching once decode accepts it.
    localparam logic [OPC_W-1:0] HALT_OPC_DEFAULT = 6'h3F;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: synchronous FIFO of {pc, instr} pairs between fetch and decode.
// Flush empties the buffer and takes priority over push and pop in the same cycle.
module fetch_skid_buffer #(
    parameter int unsigned ADDR_W  = 72,
    parameter int unsigned INSTR_W = 72,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [INSTR_W-1:0]       head_instr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against occupancy; a full buffer can still accept when popping.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != FULL_CNT) || do_pop);
    end

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            instr_mem[wr_ptr_q] <= push_instr;
        end
    end

    // Head of the queue is presented combinationally.
    always_comb begin
        count      = count_q;
        head_valid = (count_q != '0);
        head_pc    = pc_mem[rd_ptr_q];
        head_instr = instr_mem[rd_ptr_q];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues instruction fetches, buffers responses with their PC
// and hands them to decode over valid/ready. Handles redirects, flushes and HALT detection.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf_fetch / perf_stall counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 72,
    parameter int unsigned       INSTR_W    = 72,
    parameter int unsigned       PC_STEP    = 1,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [OPC_W-1:0]  HALT_OPC   = HALT_OPC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic               halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
`endif
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]   buf_count;
    logic               head_valid;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [OPC_W-1:0]   head_opc;
    logic [CNT_W:0]     occupancy;

    logic               redirect_take;
    logic               pop;
    logic               halt_take;
    logic               flush;
    logic               issue;
    logic               push;

    // Control decode: redirect, accept, HALT detection and issue credit.
    always_comb begin
        head_opc      = head_instr[INSTR_W-1 -: OPC_W];
        redirect_take = redirect_valid && (state_q != IDLE);
        pop           = head_valid && dec_ready;
        // Redirect wins over a HALT accepted in the same cycle.
        halt_take     = pop && (state_q == RUN) && (head_opc == HALT_OPC) && !redirect_valid;
        flush         = redirect_take || halt_take;
        // Buffered entries plus the outstanding response must leave room for one more.
        occupancy     = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q};
        issue         = (state_q == RUN) && (occupancy < DEPTH_LIM) && !redirect_valid
                        && !halt_take;
        // A response whose fetch predates a flush is dropped.
        push          = inflight_q && !flush;
    end

    // FSM next state: IDLE -> RUN on start, RUN -> HALT on HALT accept, HALT -> RUN on redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_take) begin
                    state_d = RUN;
                end else if (halt_take) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // PC and in-flight tracking next state; redirect loads the PC in every state.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
        if (issue) begin
            inflight_pc_d = pc_q;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_skid_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (inflight_pc_q),
        .push_instr (imem_instr),
        .pop        (pop),
        .flush      (flush),
        .count      (buf_count),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    // Output drive.
    always_comb begin
        imem_req  = issue;
        imem_addr = pc_q;
        dec_valid = head_valid;
        dec_instr = head_instr;
        dec_pc    = head_pc;
        halted    = (state_q == HALT);
        busy      = (state_q == RUN);
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // Saturating counters: issued fetches, and RUN cycles idle for reasons other than redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue && (perf_fetch_q != 32'hFFFF_FFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if ((state_q == RUN) && !issue && !redirect_valid
                && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    // Counter outputs.
    always_comb begin
        perf_fetch = perf_fetch_q;
        perf_stall = perf_stall_q;
    end
`else
    // Performance counters are absent from this build.
`endif

endmodule
